// File: rtl/event_handshake_tx.sv
// Sender side of a 4-phase req/ack link: counts single-cycle events and ships them
// one handshake at a time to a foreign clock domain, with timeout and overflow reporting.
module event_handshake_tx #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4,
    parameter int TIMEOUT     = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             evt_in,
    input  logic             ack_in,
    input  logic             clr_err,
    output logic             req_out,
    output logic             busy,
    output logic [CNT_W-1:0] pending,
    output logic             overflow,
    output logic             timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ_HI,
        ST_REQ_LO
    } state_t;

    localparam logic [CNT_W-1:0] PEND_MAX = '1;
    localparam logic [15:0]      TMO_LAST = 16'(TIMEOUT - 1);

    state_t                 r_state;
    state_t                 w_state_next;
    logic [SYNC_STAGES-1:0] r_ack_sync;
    logic [15:0]            r_tmo_cnt;
    logic [CNT_W-1:0]       r_pending;
    logic                   r_req;
    logic                   r_busy;
    logic                   r_ovf;
    logic                   r_terr;
    logic                   w_ack_s;
    logic                   w_dec;
    logic                   w_tmo;
    logic                   w_req_next;
    logic                   w_terr_set;
    logic                   w_ovf_set;

    // ack_in is asynchronous; only the last flop of the chain may be looked at.
    assign w_ack_s = r_ack_sync[SYNC_STAGES-1];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack_sync <= '0;
        end else begin
            r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], ack_in};
        end
    end

    assign w_dec     = (r_state == ST_IDLE) && (r_pending != '0);
    assign w_tmo     = (r_tmo_cnt == TMO_LAST);
    assign w_ovf_set = evt_in && !w_dec && (r_pending == PEND_MAX);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_req_next   = r_req;
        w_terr_set   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_dec) begin
                    w_state_next = ST_REQ_HI;
                    w_req_next   = 1'b1;
                end
            end
            ST_REQ_HI: begin
                if (w_ack_s) begin
                    w_state_next = ST_REQ_LO;
                    w_req_next   = 1'b0;
                end else if (w_tmo) begin
                    w_state_next = ST_REQ_LO;
                    w_req_next   = 1'b0;
                    w_terr_set   = 1'b1;
                end
            end
            ST_REQ_LO: begin
                if (!w_ack_s) begin
                    w_state_next = ST_IDLE;
                end else if (w_tmo) begin
                    w_state_next = ST_IDLE;
                    w_terr_set   = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_req_next   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_req     <= 1'b0;
            r_tmo_cnt <= '0;
            r_pending <= '0;
            r_ovf     <= 1'b0;
            r_terr    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next != ST_IDLE);
            r_req   <= w_req_next;

            // Counter restarts on every state entry and only runs in the wait states.
            if ((w_state_next != r_state) || (r_state == ST_IDLE)) begin
                r_tmo_cnt <= '0;
            end else begin
                r_tmo_cnt <= r_tmo_cnt + 16'd1;
            end

            // Simultaneous arrival and dispatch cancel out, even with the counter full.
            if (evt_in && !w_dec) begin
                if (r_pending != PEND_MAX) begin
                    r_pending <= r_pending + 1'b1;
                end
            end else if (w_dec && !evt_in) begin
                r_pending <= r_pending - 1'b1;
            end

            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (clr_err) begin
                r_ovf <= 1'b0;
            end

            if (w_terr_set) begin
                r_terr <= 1'b1;
            end else if (clr_err) begin
                r_terr <= 1'b0;
            end
        end
    end

    assign req_out     = r_req;
    assign busy        = r_busy;
    assign pending     = r_pending;
    assign overflow    = r_ovf;
    assign timeout_err = r_terr;

endmodule
